// File: rtl/axis_rr_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axis_arb_pkg
// Brief   : Shared types and helpers for the AXIS round-robin packet arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Index width that stays legal (>=1) even for a single source.
   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_rr_packet_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : axis_rr_packet_arbiter_if
// Brief   : Source-side and sink-side AXIS bundle around the packet arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface axis_rr_packet_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int DWIDTH  = 8
);
   import axis_arb_pkg::*;

   localparam int SW = src_w(NUM_SRC);

   logic [NUM_SRC*DWIDTH-1:0] s_axis_tdata;
   logic [NUM_SRC-1:0]        s_axis_tvalid;
   logic [NUM_SRC-1:0]        s_axis_tlast;
   logic [NUM_SRC-1:0]        s_axis_tready;

   logic [DWIDTH-1:0]         m_axis_tdata;
   logic                      m_axis_tvalid;
   logic                      m_axis_tready;
   logic                      m_axis_tlast;
   logic [SW-1:0]             m_axis_tid;

   // Arbiter view: consumes the sources, drives the merged stream.
   modport master (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
   );

   // Environment view: the sources plus the downstream FIFO write port.
   modport slave (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
   );

endinterface
`default_nettype wire

// File: rtl/axis_rr_packet_arbiter_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module  : axis_skid_buffer
// Brief   : Two-entry fully registered valid/ready slice (output + skid slot).
// Revision: 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic [WIDTH-1:0] in_data,
   input  wire logic             in_valid,
   output logic                  in_ready,
   output logic      [WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  wire logic             out_ready
);

   logic [WIDTH-1:0] skid_data;
   logic             skid_valid;

   // Ready comes straight from a flop so the upstream path never sees out_ready.
   assign in_ready = !skid_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
      end else if (out_ready || !out_valid) begin
         if (skid_valid) begin
            out_data   <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) begin
               out_data <= in_data;
            end
         end
      end else if (in_valid && !skid_valid) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axis_rr_packet_arbiter
// Brief   : Packet-granular round-robin arbiter merging NUM_SRC AXIS sources.
// Revision: 1.0 - initial release
// ============================================================================
module axis_rr_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int DWIDTH    = 8,
   parameter int MAX_BEATS = 256,
   parameter int CNT_W     = 16
) (
   input  wire logic              axis_aclk,
   input  wire logic              axis_aresetn,
   input  wire logic              enable,
   axis_rr_packet_arbiter_if.master axis,
   output logic                   busy,
   output logic [CNT_W-1:0]       cut_count
);

   localparam int SW   = src_w(NUM_SRC);
   localparam int BC_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
   localparam logic [BC_W-1:0] LIMIT = BC_W'(MAX_BEATS - 1);
   localparam int SKID_W = SW + 1 + DWIDTH;

   arb_state_t      state;
   logic [SW-1:0]   grant;
   logic [SW-1:0]   last_grant;
   logic [BC_W-1:0] beat_cnt;

   logic [SW-1:0]     pick;
   logic              found;
   logic              in_ready;
   logic              sel_valid;
   logic              sel_last;
   logic [DWIDTH-1:0] sel_data;
   logic              at_limit;
   logic              out_last;
   logic              accept;
   logic [SKID_W-1:0] skid_out;

   // Rotating priority: search starts one past the previous winner.
   always_comb begin
      pick  = last_grant;
      found = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         if (!found && axis.s_axis_tvalid[(int'(last_grant) + k) % NUM_SRC]) begin
            pick  = SW'((int'(last_grant) + k) % NUM_SRC);
            found = 1'b1;
         end
      end
   end

   assign sel_valid = (state == XFER) && axis.s_axis_tvalid[grant];
   assign sel_last  = axis.s_axis_tlast[grant];
   assign sel_data  = axis.s_axis_tdata[grant*DWIDTH +: DWIDTH];
   assign at_limit  = (MAX_BEATS != 0) && (beat_cnt == LIMIT);
   assign out_last  = sel_last || at_limit;
   assign accept    = sel_valid && in_ready;

   always_comb begin
      axis.s_axis_tready = '0;
      if (state == XFER) begin
         axis.s_axis_tready[grant] = in_ready;
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= SW'(NUM_SRC - 1);
         beat_cnt   <= '0;
         cut_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable && (|axis.s_axis_tvalid)) begin
                  grant <= pick;
                  state <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  if (out_last) begin
                     state      <= IDLE;
                     last_grant <= grant;
                     beat_cnt   <= '0;
                     // A limit hit without native tlast is a truncation.
                     if (!sel_last && (cut_count != {CNT_W{1'b1}})) begin
                        cut_count <= cut_count + CNT_W'(1);
                     end
                  end else begin
                     beat_cnt <= beat_cnt + BC_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   axis_skid_buffer #(
      .WIDTH(SKID_W)
   ) u_skid (
      .clk      (axis_aclk),
      .rst_n    (axis_aresetn),
      .in_data  ({grant, out_last, sel_data}),
      .in_valid (sel_valid),
      .in_ready (in_ready),
      .out_data (skid_out),
      .out_valid(axis.m_axis_tvalid),
      .out_ready(axis.m_axis_tready)
   );

   assign {axis.m_axis_tid, axis.m_axis_tlast, axis.m_axis_tdata} = skid_out;
   assign busy = (state == XFER) || axis.m_axis_tvalid;

endmodule
`default_nettype wire
